store_unit: RTL
===============

// Module: store_unit
//
// PURPOSE
// - Parametrised store path between MIPS execute stage and the Avalon-style data bus.
// - Takes one store request per handshake (sb/sh/sw) and builds the bus word with big-endian lane placement.
// - Either writes directly with byte enables or does read-modify-write when memory has no byte enables.
// - Stalls on mem_waitrequest; pulses done on completion so the CPU FSM can advance.
//
// PARAMETERS
// - ADDR_W    32  byte-address width
// - USE_BE    1   1: single masked write via mem_byteenable; 0: RMW, mem_byteenable always all-ones
//
// PORTS
// - clk              in   1       clock, rising edge
// - reset            in   1       asynchronous, active-high
// - req_valid        in   1       store request present
// - req_ready        out  1       unit idle; request accepted when req_valid && req_ready
// - req_opcode       in   6       101000 sb, 101001 sh, 101011 sw
// - req_addr         in   ADDR_W  effective byte address
// - req_data         in   32      rt register value
// - mem_address      out  ADDR_W  word address (req_addr with [1:0] forced to 0)
// - mem_read         out  1       bus read strobe (RMW only)
// - mem_write        out  1       bus write strobe
// - mem_waitrequest  in   1       bus stall; strobes and address held while high
// - mem_readdata     in   32      valid in cycle mem_read && !mem_waitrequest
// - mem_writedata    out  32      merged store word
// - mem_byteenable   out  4       lane k enables mem bits [8k+7:8k]
// - done             out  1       one-cycle pulse: request complete
// - misaligned       out  1       one-cycle pulse with done (STORE_MISALIGN_TRAP_EN only)
//
// BEHAVIOUR
// - Lane map: byte offset k -> bus bits [8k+7:8k]; CPU big-endian: sw puts rt[31:24] at offset 0.
//   sw: wdata={rt[7:0],rt[15:8],rt[23:16],rt[31:24]}, be=1111.
//   sh off 0: lanes0,1 = rt[15:8],rt[7:0], be=0011; off 2: lanes2,3, be=1100.
//   sb off k: lane k = rt[7:0], be=1<<k. Unused lanes zero (USE_BE=1) or old data (RMW).
// - FSM states: IDLE, READ, WRITE, DONE. Registers opcode/addr/data captured on accept.
// - IDLE: req_ready=1. Accept -> WRITE if sw or USE_BE=1; else READ. Invalid opcode -> DONE, no bus access.
// - READ: mem_read=1 until !mem_waitrequest; that cycle latch mem_readdata, merge -> WRITE.
// - WRITE: mem_write=1 with stable address/data/be until !mem_waitrequest -> DONE.
// - DONE: done=1 one cycle -> IDLE. req_ready=0 in all non-IDLE states (no back-to-back overlap).
// - Latency (waitrequest low): masked/sw = 3 cycles accept->done; RMW = 4 cycles.
// - mem_read and mem_write never high together.
// - Reset (any time, incl. mid-transaction): state IDLE, req_ready=1, mem_read=mem_write=done=misaligned=0,
//   mem_address=mem_writedata=0, mem_byteenable=0; in-flight store abandoned.
//
// CONFIGURATION
// - STORE_MISALIGN_TRAP_EN defined: sh with addr[0]=1 or sw with addr[1:0]!=0 -> DONE directly,
//   no bus access, misaligned=1 with done.
// - Not defined: misaligned port absent; low address bits ignored (sh uses addr[1], sw offset 0).
//
// STRUCTURE
// - Package mips_pkg: opcode localparams OP_SB/OP_SH/OP_SW, store_state_t enum.
// - Sub-module store_lane_merge (combinational: opcode, offset, rt, old word -> wdata, be), reusable by cache.
//
// TESTING
// - USE_BE=1, sw addr 0x100 rt 0x11223344 -> write 0x44332211 be 1111 @0x100, done at cycle+3.
// - USE_BE=1, sb addr 0x203 rt 0xAB -> wdata 0xAB000000, be 1000, addr 0x200.
// - USE_BE=0, sh addr 0x302 rt 0xBEEF, readdata 0x12345678 -> write 0xEFBE5678, be 1111, done at +4.
// - waitrequest held 3 cycles in READ and WRITE -> strobes/address stable, done only after release.
// - reset asserted during WRITE -> mem_write drops immediately, no done, next request served normally.
// - Trap on: sw addr 0x101 -> done+misaligned same cycle, zero bus strobes; trap off -> write @0x100.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the store path: store opcodes, store FSM
// state type and an opcode classification helper.
package mips_pkg;

    localparam logic [5:0] OP_SB = 6'b101000;
    localparam logic [5:0] OP_SH = 6'b101001;
    localparam logic [5:0] OP_SW = 6'b101011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_DONE
    } store_state_t;

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational big-endian lane placement for sb/sh/sw. Byte offset k maps
// to bus bits [8k+7:8k]; lanes not written by the store keep old_word
// (pass zero for a masked write). sh uses offset[1] only, sw ignores offset.
module store_lane_merge
    import mips_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [1:0]  offset,
    input  logic [31:0] rt,
    input  logic [31:0] old_word,
    output logic [31:0] wdata,
    output logic [3:0]  be
);

    logic [31:0] new_word;

    // Place store bytes on their lanes and build the lane mask
    always_comb begin
        new_word = '0;
        be       = '0;
        case (opcode)
            OP_SW: begin
                new_word = {rt[7:0], rt[15:8], rt[23:16], rt[31:24]};
                be       = 4'b1111;
            end
            OP_SH: begin
                if (offset[1]) begin
                    new_word[31:16] = {rt[7:0], rt[15:8]};
                    be              = 4'b1100;
                end else begin
                    new_word[15:0] = {rt[7:0], rt[15:8]};
                    be             = 4'b0011;
                end
            end
            OP_SB: begin
                new_word = {4{rt[7:0]}};
                be       = 4'b0001 << offset;
            end
            default: begin
                new_word = '0;
                be       = '0;
            end
        endcase
    end

    // Merge enabled lanes over the old word
    always_comb begin
        wdata = old_word;
        for (int unsigned k = 0; k < 4; k++) begin
            if (be[k]) begin
                wdata[8*k +: 8] = new_word[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/store_unit.sv
// Store path between the MIPS execute stage and an Avalon-style data bus.
// USE_BE=1: one masked write; USE_BE=0: read-modify-write with all lanes
// enabled. Optional macro STORE_MISALIGN_TRAP_EN adds the misaligned port
// and completes misaligned sh/sw without touching the bus.
module store_unit
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned USE_BE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        req_opcode,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    input  logic              mem_waitrequest,
    input  logic [31:0]       mem_readdata,
    output logic [31:0]       mem_writedata,
    output logic [3:0]        mem_byteenable,
    output logic              done
`ifdef STORE_MISALIGN_TRAP_EN
    ,
    output logic              misaligned
`endif
);

    store_state_t      state, state_nxt;
    logic [5:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic              accept;
    logic              trap;
    logic [5:0]        m_op;
    logic [1:0]        m_off;
    logic [31:0]       m_rt;
    logic [31:0]       m_old;
    logic [31:0]       m_wdata;
    logic [3:0]        m_be;

    assign accept = req_valid && (state == ST_IDLE);

`ifdef STORE_MISALIGN_TRAP_EN
    logic mis_q;
    assign trap = ((req_opcode == OP_SH) && req_addr[0]) ||
                  ((req_opcode == OP_SW) && (req_addr[1:0] != 2'b00));
    assign misaligned = (state == ST_DONE) && mis_q;
`else
    assign trap = 1'b0;
`endif

    // One merge instance: fed from the request at accept (zero background),
    // from the captured request plus read data when the RMW read completes
    always_comb begin
        m_op  = req_opcode;
        m_off = req_addr[1:0];
        m_rt  = req_data;
        m_old = '0;
        if (state == ST_READ) begin
            m_op  = op_q;
            m_off = addr_q[1:0];
            m_rt  = data_q;
            m_old = mem_readdata;
        end
    end

    store_lane_merge u_merge (
        .opcode   (m_op),
        .offset   (m_off),
        .rt       (m_rt),
        .old_word (m_old),
        .wdata    (m_wdata),
        .be       (m_be)
    );

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (!is_store(req_opcode) || trap) begin
                        state_nxt = ST_DONE;
                    end else if ((req_opcode == OP_SW) || (USE_BE != 0)) begin
                        state_nxt = ST_WRITE;
                    end else begin
                        state_nxt = ST_READ;
                    end
                end
            end
            ST_READ:  if (!mem_waitrequest) state_nxt = ST_WRITE;
            ST_WRITE: if (!mem_waitrequest) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Request capture and bus word/lane registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
`ifdef STORE_MISALIGN_TRAP_EN
            mis_q   <= 1'b0;
`endif
        end else if (accept) begin
            op_q    <= req_opcode;
            addr_q  <= req_addr;
            data_q  <= req_data;
            wdata_q <= m_wdata;
            be_q    <= (USE_BE != 0) ? m_be : 4'b1111;
`ifdef STORE_MISALIGN_TRAP_EN
            mis_q   <= trap;
`endif
        end else if ((state == ST_READ) && !mem_waitrequest) begin
            wdata_q <= m_wdata;
        end
    end

    assign req_ready      = (state == ST_IDLE);
    assign mem_read       = (state == ST_READ);
    assign mem_write      = (state == ST_WRITE);
    assign done           = (state == ST_DONE);
    assign mem_address    = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_writedata  = wdata_q;
    assign mem_byteenable = be_q;

endmodule
